// File: rtl/ifu_fetchq_module.sv
// +----------------------------------------------------------------------------+
// | ifu_fetchq_module: fetch address generator with tagged in-flight queue     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu_fetchq_module #(
  parameter int PC_WIDTH     = 32,
  parameter int FETCH_BYTES  = 16,
  parameter int AQ_DEPTH     = 4,
  parameter int ROB_ID_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0] BOOT_ADDR = {{(PC_WIDTH-4){1'b1}}, 4'b0}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_csr_trap_flush,
  input  logic [PC_WIDTH-1:0]           i_csr_trap_addr,
  input  logic                          i_exu_mis_flush,
  input  logic [PC_WIDTH-1:0]           i_exu_mis_addr,
  input  logic [ROB_ID_WIDTH-1:0]       i_exu_mis_rob_id,
  input  logic                          i_exu_ls_flush,
  input  logic [PC_WIDTH-1:0]           i_exu_ls_addr,
  input  logic [ROB_ID_WIDTH-1:0]       i_exu_ls_rob_id,
  input  logic                          i_iq_uc_flush,
  input  logic [PC_WIDTH-1:0]           i_iq_uc_pc_addr,
  input  logic                          i_iq_flush,
  input  logic [PC_WIDTH-1:0]           i_iq_pc_addr,
  input  logic                          i_bpu_flush,
  input  logic [PC_WIDTH-1:0]           i_bpu_pc_addr,
  input  logic                          i_icache_ifu_stall,
  input  logic                          i_icache_ifu_vld,
  input  logic [$clog2(AQ_DEPTH):0]     i_icache_ifu_id,
  output logic                          o_ifu_icache_vld,
  output logic [PC_WIDTH-1:0]           o_ifu_icache_pc_addr,
  output logic [$clog2(AQ_DEPTH):0]     o_ifu_icache_id,
  output logic                          o_ifu_bpu_vld,
  output logic [PC_WIDTH-1:0]           o_ifu_bpu_pc_addr,
  output logic                          o_ifu_predec_vld,
  output logic [PC_WIDTH-1:0]           o_ifu_predec_pc_addr,
  output logic [$clog2(AQ_DEPTH):0]     o_ifu_aq_cnt
);

  localparam int c_IDX_W = $clog2(AQ_DEPTH);
  localparam int c_CNT_W = c_IDX_W + 1;
  localparam logic [PC_WIDTH-1:0] c_BLK_MASK = PC_WIDTH'(FETCH_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] c_BLK_SIZE = PC_WIDTH'(FETCH_BYTES);

  logic [PC_WIDTH-1:0] r_pc;
  logic [c_IDX_W-1:0]  r_tail;
  logic                r_epoch;
  logic [AQ_DEPTH-1:0] r_valid;
  logic [PC_WIDTH-1:0] r_entry_pc [AQ_DEPTH];
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_predec_vld;
  logic [PC_WIDTH-1:0] r_predec_pc;

  logic                w_flush;
  logic                w_exu_sel_ls;
  logic [PC_WIDTH-1:0] w_exu_addr;
  logic [PC_WIDTH-1:0] w_flush_addr;
  logic                w_full;
  logic                w_fire;
  logic                w_match;
  logic [c_IDX_W-1:0]  w_rsp_idx;
  logic                w_rsp_epoch;

  // Wrap-bit aware age compare: a is older than b.
  function automatic logic rob_older(input logic [ROB_ID_WIDTH-1:0] a,
                                     input logic [ROB_ID_WIDTH-1:0] b);
    logic same_wrap;
    same_wrap = (a[ROB_ID_WIDTH-1] == b[ROB_ID_WIDTH-1]);
    return (same_wrap  & (a[ROB_ID_WIDTH-2:0] <  b[ROB_ID_WIDTH-2:0])) |
           (~same_wrap & (a[ROB_ID_WIDTH-2:0] >= b[ROB_ID_WIDTH-2:0]));
  endfunction

  assign w_flush = i_csr_trap_flush | i_exu_mis_flush | i_exu_ls_flush |
                   i_iq_uc_flush | i_iq_flush | i_bpu_flush;

  // Equal IDs fall to the mispredict target.
  assign w_exu_sel_ls = i_exu_ls_flush &
                        (~i_exu_mis_flush | rob_older(i_exu_ls_rob_id, i_exu_mis_rob_id));
  assign w_exu_addr   = w_exu_sel_ls ? i_exu_ls_addr : i_exu_mis_addr;

  always_comb begin
    w_flush_addr = i_bpu_pc_addr;
    if (i_csr_trap_flush)                        w_flush_addr = i_csr_trap_addr;
    else if (i_exu_mis_flush | i_exu_ls_flush)   w_flush_addr = w_exu_addr;
    else if (i_iq_uc_flush)                      w_flush_addr = i_iq_uc_pc_addr;
    else if (i_iq_flush)                         w_flush_addr = i_iq_pc_addr;
  end

  assign w_full      = r_valid[r_tail];
  assign w_fire      = ~rst & ~w_full & ~i_icache_ifu_stall & ~w_flush;
  assign w_rsp_idx   = i_icache_ifu_id[c_IDX_W-1:0];
  assign w_rsp_epoch = i_icache_ifu_id[c_IDX_W];
  assign w_match     = i_icache_ifu_vld & ~w_flush & (w_rsp_epoch == r_epoch) &
                       r_valid[w_rsp_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= BOOT_ADDR;
      r_tail       <= '0;
      r_epoch      <= 1'b0;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_predec_vld <= 1'b0;
      r_predec_pc  <= '0;
      for (int i = 0; i < AQ_DEPTH; i++) r_entry_pc[i] <= '0;
    end else begin
      r_predec_vld <= w_match;
      if (w_match) r_predec_pc <= r_entry_pc[w_rsp_idx];
      if (w_flush) begin
        r_pc    <= w_flush_addr;
        r_valid <= '0;
        r_tail  <= '0;
        r_epoch <= ~r_epoch;
        r_cnt   <= '0;
      end else begin
        // The entry being written is invalid, so it never collides with a response.
        if (w_fire) begin
          r_entry_pc[r_tail] <= r_pc;
          r_valid[r_tail]    <= 1'b1;
          r_tail             <= r_tail + 1'b1;
          r_pc               <= (r_pc & ~c_BLK_MASK) + c_BLK_SIZE;
        end
        if (w_match) r_valid[w_rsp_idx] <= 1'b0;
        r_cnt <= r_cnt + c_CNT_W'(w_fire) - c_CNT_W'(w_match);
      end
    end
  end

  assign o_ifu_icache_vld     = w_fire;
  assign o_ifu_icache_pc_addr = r_pc;
  assign o_ifu_icache_id      = {r_epoch, r_tail};
  assign o_ifu_bpu_vld        = w_fire;
  assign o_ifu_bpu_pc_addr    = r_pc;
  assign o_ifu_predec_vld     = r_predec_vld;
  assign o_ifu_predec_pc_addr = r_predec_pc;
  assign o_ifu_aq_cnt         = r_cnt;

endmodule

`default_nettype wire
